lcd_bus_receiver: RTL and testbench
===================================

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 Parameter CLR_VALUE, default 8'h20, is the character written to every DDRAM cell by reset and by the clear command.
REQ-002 clk  input  1  Single clock; all state updates on posedge clk.
REQ-003 rst  input  1  Asynchronous, active-low reset.
REQ-004 dataIn  input  8  HD44780-style bus data from the driver.
REQ-005 RS  input  1  Register select: 0 = command, 1 = character data.
REQ-006 RW  input  1  1 = read request. Reads are not supported.
REQ-007 enableIn  input  1  Bus enable from the driver. A transaction commits on its falling edge.
REQ-008 rdAddr  input  5  Display-cell read address: 0-15 is the top line, 16-31 is the bottom line.
REQ-009 rdChar  output  8  Contents of DDRAM[rdAddr], registered.
REQ-010 cursorPos  output  5  Current write position, 0-31.
REQ-011 displayOn, cursorOn, blinkOn  output  1 each  Display-control flags.
REQ-012 busy  output  1  High while the clear operation is in progress.
REQ-013 charWr  output  1  One-cycle pulse per committed character write.
REQ-014 errFlag  output  1  Sticky protocol-error flag.

Function
REQ-015 Register enableIn into en_q each cycle. A strobe is en_q=1 and enableIn=0. dataIn and RS are sampled in the strobe cycle.
REQ-016 A strobe with RW=1 causes no state change and sets errFlag.
REQ-017 A strobe while busy=1 (including the final CLEAR cycle) causes no state change and sets errFlag.
REQ-018 The internal memory is DDRAM, 32x8 registers. entryInc is an internal flag; reset value 1 means increment.
REQ-019 An RS=0 strobe is decoded by the most significant set bit of dataIn:
- 8'h00: no-op.
- 0000_0001 (clear): enter CLEAR; cursorPos<=0; entryInc<=1.
- 0000_001x (home): cursorPos<=0.
- 0000_01IS (entry mode): entryInc<=I; S ignored.
- 0000_1DCB (display control): displayOn<=D, cursorOn<=C, blinkOn<=B.
- 0001_xxxx, 001x_xxxx, 01xx_xxxx (shift, function set, CGRAM): accepted, no effect.
- 1AAA_AAAA (set DDRAM address): A=0x00-0x0F gives cursorPos=A. A=0x40-0x4F gives cursorPos=A-0x30. Any other A leaves cursorPos unchanged and sets errFlag.
REQ-020 An RS=1 strobe writes DDRAM[cursorPos]<=dataIn and pulses charWr for the following cycle.
- On the same edge, cursorPos <= cursorPos±1 modulo 32.
- Wrap is 31->0 on increment and 0->31 on decrement.
REQ-021 The state machine has two states, IDLE and CLEAR. Reset state is IDLE.
- IDLE->CLEAR: on a clear command, with clrIdx<=0.
- In CLEAR: each cycle DDRAM[clrIdx]<=CLR_VALUE and clrIdx increments.
- CLEAR->IDLE: after clrIdx=31 is written.
- busy=1 exactly while in CLEAR, which lasts 32 cycles.
REQ-022 rdChar<=DDRAM[rdAddr] every cycle, giving 1-cycle read latency. A read of the cell being written in the same cycle returns the old value.
REQ-023 errFlag is cleared only by reset.

Reset
REQ-024 While rst=0, asynchronously, the block SHALL:
- return to IDLE;
- set all DDRAM cells to CLR_VALUE;
- clear cursorPos, clrIdx, en_q, displayOn, cursorOn, blinkOn, busy, charWr, errFlag and rdChar to 0, and set entryInc to 1.
REQ-025 A reset asserted during CLEAR aborts the clear immediately. No strobe is recognised until one full enable high-then-low sequence is seen after reset release.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Reset: rdAddr sweep 0-31 returns 8'h20 for every cell; cursorPos=0, busy=0, errFlag=0.
- Init sequence strobes 0x0E, 0x06, 0x01, 0x02: displayOn=1, cursorOn=1, blinkOn=0; busy=1 for exactly 32 cycles after the 0x01 strobe; cursorPos=0.
- Strobe 0xC0, then RS=1 strobes 0x31 and 0x30: DDRAM[16]=0x31, DDRAM[17]=0x30, cursorPos=18, two charWr pulses.
- Wrap: 0xCF then write 'A' gives DDRAM[31]=0x41 and cursorPos=0. Then 0x04 and write 'B' gives DDRAM[0]=0x42 and cursorPos=31.
- Errors: strobe during busy, strobe 0x90, and strobe with RW=1 each leave DDRAM and cursorPos unchanged and set errFlag=1.
- Reset asserted mid-CLEAR at clrIdx=10: busy drops immediately and all cells read 0x20 after release.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - HD44780-style bus receiver with 32-cell DDRAM
//
// Purpose: decodes driver bus transactions (committed on the falling edge of
// enableIn) into display-control state and a 2x16 character DDRAM.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   dataIn[7:0]     bus data; RS selects command (0) / character (1)
//   RW              read request (unsupported, flagged as error)
//   enableIn        bus enable; falling edge commits a transaction
//   rdAddr[4:0]     display-cell read address (0-15 top, 16-31 bottom)
//   rdChar[7:0]     registered DDRAM[rdAddr]
//   cursorPos[4:0]  current write position
//   displayOn, cursorOn, blinkOn  display-control flags
//   busy            high while the clear sweep runs
//   charWr          one-cycle pulse per committed character write
//   errFlag         sticky protocol-error flag
module lcd_bus_receiver #(
  parameter logic [7:0] CLR_VALUE = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataIn,
  input  logic       RS,
  input  logic       RW,
  input  logic       enableIn,
  input  logic [4:0] rdAddr,
  output logic [7:0] rdChar,
  output logic [4:0] cursorPos,
  output logic       displayOn,
  output logic       cursorOn,
  output logic       blinkOn,
  output logic       busy,
  output logic       charWr,
  output logic       errFlag
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_en_q;
  logic [4:0]  r_cursor;
  logic [4:0]  r_clr_idx;
  logic        r_entry_inc;
  logic        r_disp;
  logic        r_curs;
  logic        r_blink;
  logic        r_char_wr;
  logic        r_err;
  logic [7:0]  r_rd_char;
  logic [7:0]  r_ddram [32];

  logic        w_strobe;
  logic        w_busy;
  logic        w_accept;
  logic        w_cmd;
  logic        w_data_wr;
  logic        w_clr_cmd;
  logic [6:0]  w_addr;
  logic        w_addr_top;
  logic        w_addr_bot;
  logic        w_addr_bad;

  // en_q resets to 0, so after reset release a strobe needs a fresh high-then-low.
  assign w_strobe   = r_en_q & ~enableIn;
  assign w_busy     = (r_state == ST_CLEAR);
  assign w_accept   = w_strobe & ~RW & ~w_busy;
  assign w_cmd      = w_accept & ~RS;
  assign w_data_wr  = w_accept & RS;
  assign w_clr_cmd  = w_cmd & (dataIn == 8'h01);

  // Set-DDRAM-address: line 1 is 0x00-0x0F, line 2 is 0x40-0x4F.
  assign w_addr     = dataIn[6:0];
  assign w_addr_top = dataIn[7] & (w_addr[6:4] == 3'b000);
  assign w_addr_bot = dataIn[7] & (w_addr[6:4] == 3'b100);
  assign w_addr_bad = dataIn[7] & ~w_addr_top & ~w_addr_bot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_clr_cmd) w_state_next = ST_CLEAR;
      ST_CLEAR: if (r_clr_idx == 5'd31) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_ddram[i] <= CLR_VALUE;
      r_en_q      <= 1'b0;
      r_cursor    <= 5'd0;
      r_clr_idx   <= 5'd0;
      r_entry_inc <= 1'b1;
      r_disp      <= 1'b0;
      r_curs      <= 1'b0;
      r_blink     <= 1'b0;
      r_char_wr   <= 1'b0;
      r_err       <= 1'b0;
      r_rd_char   <= 8'd0;
    end else begin
      r_en_q    <= enableIn;
      r_char_wr <= w_data_wr;
      // Nonblocking read: a same-cycle write to this cell returns the old value.
      r_rd_char <= r_ddram[rdAddr];

      if ((w_strobe & (RW | w_busy)) | (w_cmd & w_addr_bad))
        r_err <= 1'b1;

      if (w_busy) begin
        r_ddram[r_clr_idx] <= CLR_VALUE;
        r_clr_idx          <= r_clr_idx + 5'd1;
      end

      if (w_data_wr) begin
        r_ddram[r_cursor] <= dataIn;
        r_cursor          <= r_entry_inc ? r_cursor + 5'd1 : r_cursor - 5'd1;
      end

      if (w_cmd) begin
        casez (dataIn)
          8'b1???_????: begin
            if (w_addr_top)      r_cursor <= w_addr[4:0];
            else if (w_addr_bot) r_cursor <= {1'b1, w_addr[3:0]};
          end
          8'b01??_????, 8'b001?_????, 8'b0001_????: begin
          end
          8'b0000_1???: begin
            r_disp  <= dataIn[2];
            r_curs  <= dataIn[1];
            r_blink <= dataIn[0];
          end
          8'b0000_01??: r_entry_inc <= dataIn[1];
          8'b0000_001?: r_cursor    <= 5'd0;
          8'b0000_0001: begin
            r_cursor    <= 5'd0;
            r_entry_inc <= 1'b1;
            r_clr_idx   <= 5'd0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rdChar    = r_rd_char;
  assign cursorPos = r_cursor;
  assign displayOn = r_disp;
  assign cursorOn  = r_curs;
  assign blinkOn   = r_blink;
  assign busy      = w_busy;
  assign charWr    = r_char_wr;
  assign errFlag   = r_err;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - directed self-checking bench for lcd_bus_receiver
module tb_lcd_bus_receiver;

  logic       clk;
  logic       rst;
  logic [7:0] dataIn;
  logic       RS;
  logic       RW;
  logic       enableIn;
  logic [4:0] rdAddr;
  logic [7:0] rdChar;
  logic [4:0] cursorPos;
  logic       displayOn;
  logic       cursorOn;
  logic       blinkOn;
  logic       busy;
  logic       charWr;
  logic       errFlag;

  int errors = 0;
  int checks = 0;

  lcd_bus_receiver #(.CLR_VALUE(8'h20)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .RS(RS), .RW(RW),
    .enableIn(enableIn), .rdAddr(rdAddr), .rdChar(rdChar),
    .cursorPos(cursorPos), .displayOn(displayOn), .cursorOn(cursorOn),
    .blinkOn(blinkOn), .busy(busy), .charWr(charWr), .errFlag(errFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enable high for one cycle, then low: the strobe commits on the second edge.
  task automatic bus_strobe(input logic rs, input logic [7:0] d, input logic rw);
    RS = rs; RW = rw; dataIn = d; enableIn = 1'b1;
    tick();
    enableIn = 1'b0;
    tick();
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] v);
    rdAddr = a;
    tick();
    v = rdChar;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; enableIn = 1'b0; RS = 1'b0; RW = 1'b0; dataIn = 8'h00; rdAddr = 5'd0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      read_cell(i[4:0], v);
      checks++;
      if (v !== 8'h20) begin
        errors++;
        $display("FAIL reset_cell[%0d] got %h expected 20", i, v);
      end
    end
    checks++;
    if ({cursorPos, busy, errFlag, charWr, displayOn} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state cursor=%0d busy=%b err=%b charWr=%b disp=%b expected all 0",
               cursorPos, busy, errFlag, charWr, displayOn);
    end
  endtask

  task automatic test_init();
    int n;
    bus_strobe(1'b0, 8'h0E, 1'b0);
    bus_strobe(1'b0, 8'h06, 1'b0);
    bus_strobe(1'b0, 8'h01, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL init_busy_cycles got %0d expected 32", n);
    end
    bus_strobe(1'b0, 8'h02, 1'b0);
    checks++;
    if ({displayOn, cursorOn, blinkOn} !== 3'b110) begin
      errors++;
      $display("FAIL init_flags got %b expected 110", {displayOn, cursorOn, blinkOn});
    end
    checks++;
    if (cursorPos !== 5'd0 || errFlag !== 1'b0) begin
      errors++;
      $display("FAIL init_cursor cursor=%0d err=%b expected 0 0", cursorPos, errFlag);
    end
  endtask

  task automatic test_line2_write();
    logic [7:0] v;
    int pulses = 0;
    bus_strobe(1'b0, 8'hC0, 1'b0);
    checks++;
    if (cursorPos !== 5'd16) begin
      errors++;
      $display("FAIL line2_addr cursor=%0d expected 16", cursorPos);
    end
    bus_strobe(1'b1, 8'h31, 1'b0);
    if (charWr === 1'b1) pulses++;
    bus_strobe(1'b1, 8'h30, 1'b0);
    if (charWr === 1'b1) pulses++;
    tick();
    checks++;
    if (pulses !== 2 || charWr !== 1'b0) begin
      errors++;
      $display("FAIL charwr_pulses got %0d (charWr now %b) expected 2 (0)", pulses, charWr);
    end
    read_cell(5'd16, v);
    checks++;
    if (v !== 8'h31) begin
      errors++;
      $display("FAIL ddram16 got %h expected 31", v);
    end
    read_cell(5'd17, v);
    checks++;
    if (v !== 8'h30) begin
      errors++;
      $display("FAIL ddram17 got %h expected 30", v);
    end
    checks++;
    if (cursorPos !== 5'd18) begin
      errors++;
      $display("FAIL line2_cursor got %0d expected 18", cursorPos);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    bus_strobe(1'b0, 8'hCF, 1'b0);
    bus_strobe(1'b1, 8'h41, 1'b0);
    read_cell(5'd31, v);
    checks++;
    if (v !== 8'h41 || cursorPos !== 5'd0) begin
      errors++;
      $display("FAIL wrap_inc cell31=%h cursor=%0d expected 41 0", v, cursorPos);
    end
    bus_strobe(1'b0, 8'h04, 1'b0);
    bus_strobe(1'b1, 8'h42, 1'b0);
    read_cell(5'd0, v);
    checks++;
    if (v !== 8'h42 || cursorPos !== 5'd31) begin
      errors++;
      $display("FAIL wrap_dec cell0=%h cursor=%0d expected 42 31", v, cursorPos);
    end
  endtask

  task automatic test_errors();
    logic [7:0] v;
    // Strobe during busy: write attempt ignored.
    do_reset();
    bus_strobe(1'b0, 8'h01, 1'b0);
    bus_strobe(1'b1, 8'h51, 1'b0);
    wait_not_busy();
    read_cell(5'd0, v);
    checks++;
    if (v !== 8'h20 || cursorPos !== 5'd0 || errFlag !== 1'b1) begin
      errors++;
      $display("FAIL err_busy cell0=%h cursor=%0d err=%b expected 20 0 1", v, cursorPos, errFlag);
    end
    // Invalid address 0x90.
    do_reset();
    bus_strobe(1'b0, 8'h85, 1'b0);
    bus_strobe(1'b1, 8'h5A, 1'b0);
    bus_strobe(1'b0, 8'h90, 1'b0);
    read_cell(5'd5, v);
    checks++;
    if (v !== 8'h5A || cursorPos !== 5'd6 || errFlag !== 1'b1) begin
      errors++;
      $display("FAIL err_addr cell5=%h cursor=%0d err=%b expected 5a 6 1", v, cursorPos, errFlag);
    end
    // RW=1 character strobe.
    do_reset();
    bus_strobe(1'b0, 8'h85, 1'b0);
    bus_strobe(1'b1, 8'h58, 1'b1);
    read_cell(5'd5, v);
    checks++;
    if (v !== 8'h20 || cursorPos !== 5'd5 || errFlag !== 1'b1 || charWr !== 1'b0) begin
      errors++;
      $display("FAIL err_rw cell5=%h cursor=%0d err=%b charWr=%b expected 20 5 1 0",
               v, cursorPos, errFlag, charWr);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] v;
    int bad = 0;
    do_reset();
    bus_strobe(1'b0, 8'h8A, 1'b0);
    bus_strobe(1'b1, 8'h61, 1'b0);
    bus_strobe(1'b0, 8'hC4, 1'b0);
    bus_strobe(1'b1, 8'h62, 1'b0);
    bus_strobe(1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midclear_busy got %b expected 0", busy);
    end
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      read_cell(i[4:0], v);
      if (v !== 8'h20) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midclear_cells %0d cells not 20, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_line2_write();
    test_wrap();
    test_errors();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
